// File: rtl/src_alu_pkg.sv
// Shared constants and types for the Mini SRC datapath ALU.
// The opcode table lives here so that the ALU and any decoder agree on the encoding.
package src_alu_pkg;

  localparam int WIDTH   = 32;
  localparam int OP_BITS = 5;

  typedef logic [2*WIDTH-1:0] result_t;

  localparam logic [OP_BITS-1:0] OP_OR    = 5'h00;
  localparam logic [OP_BITS-1:0] OP_ADD   = 5'h01;
  localparam logic [OP_BITS-1:0] OP_AND   = 5'h02;
  localparam logic [OP_BITS-1:0] OP_SUB   = 5'h03;
  localparam logic [OP_BITS-1:0] OP_SHR   = 5'h04;
  localparam logic [OP_BITS-1:0] OP_SHRA  = 5'h05;
  localparam logic [OP_BITS-1:0] OP_SHL   = 5'h06;
  localparam logic [OP_BITS-1:0] OP_ROR   = 5'h07;
  localparam logic [OP_BITS-1:0] OP_ROL   = 5'h08;
  localparam logic [OP_BITS-1:0] OP_MUL   = 5'h09;
  localparam logic [OP_BITS-1:0] OP_DIV   = 5'h0A;
  localparam logic [OP_BITS-1:0] OP_NEG   = 5'h0B;
  localparam logic [OP_BITS-1:0] OP_NOT   = 5'h0C;
  localparam logic [OP_BITS-1:0] OP_BRA   = 5'h0D;
  localparam logic [OP_BITS-1:0] OP_INCPC = 5'h0E;

endpackage

// File: rtl/src_alu_div.sv
// Combinational signed divider: unsigned restoring array on magnitudes, then sign fix-up.
// Quotient truncates toward zero; the remainder follows the sign of the dividend.
module src_alu_div
  import src_alu_pkg::*;
(
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic             neg_q;
  logic             neg_r;
  logic             overflow;
  logic [WIDTH-1:0] mag_n;
  logic [WIDTH-1:0] mag_d;
  logic [WIDTH-1:0] q_bits;
  logic [WIDTH-1:0] part_rem [0:WIDTH];

  assign neg_q       = dividend[WIDTH-1] ^ divisor[WIDTH-1];
  assign neg_r       = dividend[WIDTH-1];
  assign mag_n       = dividend[WIDTH-1] ? -dividend : dividend;
  assign mag_d       = divisor[WIDTH-1]  ? -divisor  : divisor;
  assign div_by_zero = (divisor == '0);
  // The only quotient that does not fit: most-negative / -1 wraps back to itself.
  assign overflow    = (dividend == MIN_NEG) && (divisor == '1);

  assign part_rem[0] = '0;

  // One stage per dividend bit, MSB first; a negative trial difference restores.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage
      logic [WIDTH:0] shifted;
      logic [WIDTH:0] diff;
      assign shifted = {part_rem[gi], mag_n[WIDTH-1-gi]};
      assign diff    = shifted - {1'b0, mag_d};
      assign q_bits[WIDTH-1-gi] = ~diff[WIDTH];
      assign part_rem[gi+1]     = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
    end
  endgenerate

  always_comb begin
    quotient  = '0;
    remainder = '0;
    if (overflow) begin
      quotient = MIN_NEG;
    end else if (!div_by_zero) begin
      quotient  = neg_q ? -q_bits : q_bits;
      remainder = neg_r ? -part_rem[WIDTH] : part_rem[WIDTH];
    end
  end

endmodule

// File: rtl/src_alu.sv
// Mini SRC datapath ALU: decodes the low control bits, combines Y and the bus,
// and registers a double-width result for the ZHI/ZLO pair.
module src_alu
  import src_alu_pkg::*;
(
  input  logic                 clock,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     b,
  input  logic [WIDTH-1:0]     y,
  input  logic [31:0]          control,
  input  logic                 con_flag,
  output logic [2*WIDTH-1:0]   result
);

  logic [OP_BITS-1:0]        opcode;
  logic [4:0]                shamt;
  logic [WIDTH:0]            add_sum;
  logic [WIDTH-1:0]          ror_val;
  logic [WIDTH-1:0]          rol_val;
  logic signed [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]          div_q;
  logic [WIDTH-1:0]          div_r;
  logic                      div_zero;
  logic                      ctrl_unused;
  result_t                   result_next;
  result_t                   result_reg;

  assign opcode      = control[OP_BITS-1:0];
  assign ctrl_unused = ^control[31:OP_BITS];
  assign shamt       = b[4:0];
  assign add_sum     = {1'b0, y} + {1'b0, b};
  assign product     = $signed(y) * $signed(b);

  // A shift by the full width yields zero, so amount 0 leaves y untouched.
  assign ror_val = (y >> shamt) | (y << (6'd32 - {1'b0, shamt}));
  assign rol_val = (y << shamt) | (y >> (6'd32 - {1'b0, shamt}));

  src_alu_div u_div (
    .dividend    (y),
    .divisor     (b),
    .quotient    (div_q),
    .remainder   (div_r),
    .div_by_zero (div_zero)
  );

  always_comb begin
    result_next = '0;
    case (opcode)
      OP_OR:    result_next[WIDTH-1:0] = y | b;
      OP_ADD:   result_next[WIDTH:0]   = add_sum;
      OP_AND:   result_next[WIDTH-1:0] = y & b;
      OP_SUB:   result_next[WIDTH-1:0] = y - b;
      OP_SHR:   result_next[WIDTH-1:0] = y >> shamt;
      OP_SHRA:  result_next[WIDTH-1:0] = $signed(y) >>> shamt;
      OP_SHL:   result_next[WIDTH-1:0] = y << shamt;
      OP_ROR:   result_next[WIDTH-1:0] = ror_val;
      OP_ROL:   result_next[WIDTH-1:0] = rol_val;
      OP_MUL:   result_next = product;
      OP_DIV:   if (!div_zero) result_next = {div_r, div_q};
      OP_NEG:   result_next[WIDTH-1:0] = -b;
      OP_NOT:   result_next[WIDTH-1:0] = ~b;
      OP_BRA:   result_next[WIDTH-1:0] = con_flag ? add_sum[WIDTH-1:0] : y;
      OP_INCPC: result_next[WIDTH-1:0] = b + 32'd1;
      default:  result_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) result_reg <= '0;
    else        result_reg <= result_next;
  end

  assign result = result_reg;

endmodule

// File: tb/tb_src_alu.sv
// Randomised scoreboard bench for src_alu: stimulus pushes expected results,
// a monitor pops and compares one registered result per clock.
module tb_src_alu;

  logic        clock;
  logic        clear;
  logic [31:0] b;
  logic [31:0] y;
  logic [31:0] control;
  logic        con_flag;
  logic [63:0] result;

  logic [63:0] exp_q[$];
  string       name_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  src_alu dut (
    .clock    (clock),
    .clear    (clear),
    .b        (b),
    .y        (y),
    .control  (control),
    .con_flag (con_flag),
    .result   (result)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model from arithmetic definitions.
  function automatic logic [63:0] model(input logic [31:0] yv, input logic [31:0] bv,
                                        input logic [31:0] cv, input logic cf);
    longint sy;
    longint sb;
    longint q;
    longint r;
    longint p2;
    logic [31:0] v;
    logic [63:0] res;
    int sh;
    sy  = longint'(signed'(yv));
    sb  = longint'(signed'(bv));
    sh  = int'(bv[4:0]);
    p2  = longint'(1) << sh;
    res = 64'd0;
    case (cv[4:0])
      5'h00: res = {32'd0, yv | bv};
      5'h01: res = {32'd0, yv} + {32'd0, bv};
      5'h02: res = {32'd0, yv & bv};
      5'h03: begin v = yv - bv; res = {32'd0, v}; end
      5'h04: begin v = yv >> sh; res = {32'd0, v}; end
      5'h05: begin
        if (sy >= 0) q = sy / p2;
        else         q = -(((-sy) + p2 - 1) / p2);
        res = {32'd0, q[31:0]};
      end
      5'h06: begin v = yv << sh; res = {32'd0, v}; end
      5'h07: begin
        v = yv;
        for (int k = 0; k < sh; k++) v = {v[0], v[31:1]};
        res = {32'd0, v};
      end
      5'h08: begin
        v = yv;
        for (int k = 0; k < sh; k++) v = {v[30:0], v[31]};
        res = {32'd0, v};
      end
      5'h09: begin q = sy * sb; res = q; end
      5'h0A: begin
        if (sb != 0) begin
          q = sy / sb;
          r = sy % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      5'h0B: begin v = 32'd0 - bv; res = {32'd0, v}; end
      5'h0C: res = {32'd0, ~bv};
      5'h0D: begin v = cf ? yv + bv : yv; res = {32'd0, v}; end
      5'h0E: begin v = bv + 32'd1; res = {32'd0, v}; end
      default: res = 64'd0;
    endcase
    return res;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask

  task automatic drive(input logic [31:0] yv, input logic [31:0] bv,
                       input logic [31:0] cv, input logic cf, input string nm);
    y = yv; b = bv; control = cv; con_flag = cf;
    exp_q.push_back(model(yv, bv, cv, cf));
    name_q.push_back(nm);
  endtask

  task automatic issue(input logic [31:0] yv, input logic [31:0] bv,
                       input logic [31:0] cv, input logic cf, input string nm);
    @(negedge clock);
    drive(yv, bv, cv, cf, nm);
    $display("issue %-6s y=%h b=%h ctl=%h con=%0d", nm, yv, bv, cv, cf);
  endtask

  task automatic drain();
    int budget = 20;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // Monitor: the ALU presents a fresh result every cycle, sampled just after the edge.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() != 0) begin
        logic [63:0] e;
        string nm;
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        check(nm, result, e);
        $display("check %-6s result=%h expected=%h", nm, result, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] ry;
    logic [31:0] rb;
    logic [31:0] rc;
    clear    = 1'b0;
    y        = $urandom;
    b        = $urandom;
    control  = $urandom;
    con_flag = 1'b1;
    #2;
    check("rst0", result, 64'd0);

    @(negedge clock);
    clear = 1'b1;

    issue(32'h0000_0001, 32'h0000_0010, 32'h0000_0000, 1'b0, "or");
    issue(32'h0000_FFFF, 32'h0000_F000, 32'h0000_0002, 1'b0, "and");
    issue(32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0009, 1'b0, "mul");
    issue(32'hFFFF_FFF9, 32'h0000_0002, 32'h0000_000A, 1'b0, "div");
    issue(32'h1234_5678, 32'h0000_0000, 32'h0000_000A, 1'b0, "div0");
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_000A, 1'b0, "divov");
    issue(32'h0000_0001, 32'h0000_0001, 32'h0000_0007, 1'b0, "ror");
    issue(32'hDEAD_BEEF, 32'hFFFF_FFE0, 32'h0000_0007, 1'b0, "ror0");
    issue(32'h0000_0100, 32'h0000_0020, 32'h0000_000D, 1'b1, "bra1");
    issue(32'h0000_0100, 32'h0000_0020, 32'h0000_000D, 1'b0, "bra0");
    issue(32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFE1, 1'b0, "addc");
    issue(32'h8000_0000, 32'h0000_003F, 32'h0000_0005, 1'b0, "shra");
    issue(32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_000E, 1'b0, "incpc");
    issue(32'h1111_1111, 32'h2222_2222, 32'h0000_001F, 1'b0, "illeg");
    drain();

    // Asynchronous clear mid-cycle, hold across an edge, then reload on release.
    issue(32'h0000_0005, 32'h0000_0003, 32'h0000_0001, 1'b0, "pre");
    drain();
    #2;
    clear = 1'b0;
    #1;
    check("aclr", result, 64'd0);
    @(posedge clock);
    #1;
    check("hold", result, 64'd0);
    @(negedge clock);
    clear = 1'b1;
    drive(32'h0000_0007, 32'h0000_0009, 32'h0000_0003, 1'b0, "reload");
    drain();

    for (int i = 0; i < 400; i++) begin
      ry = $urandom;
      rb = $urandom;
      rc = {$urandom_range(0, 134217727), 5'(i % 16)};
      if (i % 7 == 0) rc[4:0] = 5'($urandom_range(15, 31));
      if (rc[4:0] == 5'h0A && i % 3 == 0) rb = 32'($urandom_range(0, 9)) - 32'd4;
      issue(ry, rb, rc, 1'($urandom_range(0, 1)), "rand");
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
